// File: rtl/stack_pkg.sv
// Shared definitions for the hardware-stack sequencer: SP register control
// codes and the sequencer state type.
package stack_pkg;

  localparam logic [1:0] SP_STORE = 2'b00;
  localparam logic [1:0] SP_CLEAR = 2'b01;
  localparam logic [1:0] SP_INC   = 2'b10;
  localparam logic [1:0] SP_DEC   = 2'b11;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    PUSH,
    POP,
    POP_WAIT
  } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Push/pop sequencer driving an external falling-edge SP register and a
// synchronous stack RAM. Optional sticky error flag: define STACK_ERR_EN.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_req,
  input  logic         pop_req,
  input  logic         clr_req,
  input  logic [W-1:0] din,
  output logic         ready,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         full,
  output logic         empty,
  output logic         err,
  input  logic [N-1:0] sp_in,
  output logic [1:0]   sp_ctrl,
  output logic [N-1:0] mem_addr,
  output logic         mem_we,
  output logic         mem_re,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata
);

  state_e         state_q;
  logic [W-1:0]   dout_q;
  logic           dout_valid_q;
  logic [N-1:0]   mem_addr_q;
  logic           mem_we_q;
  logic           mem_re_q;
  logic [W-1:0]   mem_wdata_q;
`ifdef STACK_ERR_EN
  logic           err_q;
`endif

  assign full  = (sp_in == N'(DEPTH));
  assign empty = (sp_in == '0);
  assign ready = (state_q == IDLE);

  always_comb begin
    sp_ctrl = SP_STORE;
    case (state_q)
      CLR:     sp_ctrl = SP_CLEAR;
      PUSH:    sp_ctrl = SP_INC;
      POP:     sp_ctrl = SP_DEC;
      default: sp_ctrl = SP_STORE;
    endcase
  end

  // The RAM address is captured at accept time so the mid-cycle SP update
  // cannot disturb the access already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLR;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_wdata_q  <= '0;
`ifdef STACK_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      dout_valid_q <= 1'b0;
      case (state_q)
        CLR: state_q <= IDLE;
        IDLE: begin
          if (clr_req) begin
            state_q <= CLR;
`ifdef STACK_ERR_EN
            err_q   <= 1'b0;
`endif
          end else if (push_req) begin
            if (!full) begin
              state_q     <= PUSH;
              mem_addr_q  <= sp_in;
              mem_wdata_q <= din;
              mem_we_q    <= 1'b1;
            end
`ifdef STACK_ERR_EN
            else err_q <= 1'b1;
`endif
          end else if (pop_req) begin
            if (!empty) begin
              state_q    <= POP;
              mem_addr_q <= sp_in - N'(1);
              mem_re_q   <= 1'b1;
            end
`ifdef STACK_ERR_EN
            else err_q <= 1'b1;
`endif
          end
        end
        PUSH: state_q <= IDLE;
        POP:  state_q <= POP_WAIT;
        POP_WAIT: begin
          dout_q       <= mem_rdata;
          dout_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= CLR;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign mem_wdata  = mem_wdata_q;
`ifdef STACK_ERR_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Push/pop sequencer for the processor's hardware stack, sitting directly upstream of the stack-pointer register. It accepts push/pop requests over a ready/valid handshake, drives the SP register's 2-bit control code, and addresses the synchronous stack RAM from the current SP value. It also reports full/empty and sticky error status. It runs on the rising edge of `clk`; the SP register updates on the falling edge of the same clock.

## Interface
- `N`, 8: SP / address width.
- `W`, 8: data word width.
- `DEPTH`, 16: stack capacity in words; must satisfy `DEPTH <= 2**N - 1`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push_req`  in  1  push request, qualified by `ready`.
- `pop_req`  in  1  pop request, qualified by `ready`.
- `clr_req`  in  1  empty the stack, qualified by `ready`.
- `din`  in  W  push data, sampled on accept.
- `ready`  out  1  block is idle and can accept a request.
- `dout`  out  W  popped word.
- `dout_valid`  out  1  one-cycle pulse; `dout` is valid.
- `full`  out  1  `sp_in == DEPTH`.
- `empty`  out  1  `sp_in == 0`.
- `err`  out  1  sticky overflow/underflow flag (see Configuration).
- `sp_in`  in  N  current SP value, which points to the next free slot.
- `sp_ctrl`  out  2  SP register control code.
- `mem_addr`  out  N  registered RAM address.
- `mem_we`  out  1  RAM write enable.
- `mem_re`  out  1  RAM read enable; read data arrives on the next cycle.
- `mem_wdata`  out  W  RAM write data.
- `mem_rdata`  in  W  RAM read data.

## Operation
- Five states: `CLR`, `IDLE`, `PUSH`, `POP`, `POP_WAIT`.
- `sp_ctrl` is a Moore decode of the state:
  - `CLR` → 01 (clear).
  - `PUSH` → 10 (increment).
  - `POP` → 11 (decrement).
  - All other states → 00 (store).
- `IDLE`: `ready`=1. Requests are evaluated with priority clr > push > pop; only one is accepted per cycle.
  - Clear accepted → `CLR`.
  - Push with `!full` → `PUSH`. Registers `mem_addr<=sp_in`, `mem_wdata<=din`, `mem_we<=1`.
  - Pop with `!empty` → `POP`. Registers `mem_addr<=sp_in-1`, `mem_re<=1`.
- Push while `full`: not accepted; SP and RAM are untouched; `err` is set.
- Pop while `empty`: not accepted; SP and RAM are untouched; `err` is set.
- Push and pop asserted together: push wins; the pop is ignored and does not set `err`.
- `PUSH` (1 cycle): the RAM write commits at the end of this cycle. SP increments at the mid-cycle falling edge. Next state is `IDLE`.
- `POP` (1 cycle): SP decrements at the falling edge. Next state is `POP_WAIT`.
- `POP_WAIT` (1 cycle): `dout<=mem_rdata` at the end of the cycle, and `dout_valid` pulses in the following `IDLE` cycle.
- `CLR` (1 cycle): SP clears at the falling edge. Next state is `IDLE`.
- `mem_addr` is registered so that the mid-cycle SP change never moves an in-flight RAM address.
- `mem_we` and `mem_re` are high for exactly one cycle per operation.
- Arithmetic: `sp_in-1` is computed in N bits and is used only when `!empty`, so it never wraps.
- `full` and `empty` are combinational from `sp_in`; they are meaningful in `IDLE`.

## Timing
- Reset: while `rst` is sampled high, the state is forced to `CLR`.
  - The first cycle after `rst` deasserts is spent in `CLR` (`sp_ctrl`=01), then `IDLE`.
  - Reset values: `ready`=0, `dout`=0, `dout_valid`=0, `err`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation: the operation is abandoned.
  - `mem_we`/`mem_re` drop at the next edge.
  - A half-finished pop's data is discarded; `dout_valid` does not pulse.
  - SP is cleared regardless of its state.
- Push latency: accept on edge 0; write and SP+1 complete by edge 1; `ready`=1 from edge 1.
- Pop latency: accept on edge 0; `dout_valid` high in the cycle after edge 2; `ready`=1 from edge 2.
- Back-to-back operation: a new request can be accepted on the first `IDLE` edge. Sustained throughput is 1 push per 2 cycles and 1 pop per 3 cycles.

## Configuration
- `STACK_ERR_EN` defined:
  - `err` is set on a rejected overflow push or underflow pop.
  - It stays set until `rst` or an accepted clear.
- `STACK_ERR_EN` undefined:
  - `err` is tied to 0 and its register is not built.
  - Rejected requests are silently dropped; all other behaviour is identical.

## Structure
- Shared package `stack_pkg` holds:
  - `sp_ctrl` encodings: `SP_STORE`=2'b00, `SP_CLEAR`=2'b01, `SP_INC`=2'b10, `SP_DEC`=2'b11.
  - The state enum type.
- The same `sp_ctrl` encodings are used by the SP register instance at the top level.
- No sub-module. The FSM, address/data registers and status logic form one module; the SP register and RAM are instantiated beside it.

## Test plan
- Reset then idle: hold `rst` 2 cycles.
  - `sp_ctrl`=01 in the cycle after release; then `ready`=1, `empty`=1, `sp_in`=0.
- Push sequence: push 0xA1, 0xB2, 0xC3.
  - `mem_we` writes to addresses 0, 1, 2; `sp_in`=3; each push takes 2 cycles request-to-request.
- Pop sequence: pop three times after the push sequence.
  - `dout` = 0xC3, 0xB2, 0xA1 with one `dout_valid` pulse each, 3 cycles after accept; `empty`=1 at the end.
- Boundaries:
  - Fill to `DEPTH`=16 → `full`=1; a 17th push → SP stays 16 and `err`=1.
  - Pop while empty → `err`=1 and no `mem_re`.
  - Build without `STACK_ERR_EN` → `err` stays 0 in both cases.
- Simultaneous requests and clear:
  - `push_req`=`pop_req`=1 with 0x55 → push only, SP+1.
  - `clr_req` together with push → SP cleared to 0, no write.
- Reset mid-pop: assert `rst` during `POP_WAIT`.
  - No `dout_valid` pulse; `sp_ctrl`=01 after release; `sp_in`=0.
